// File: rtl/mem_wb_stage_pkg.sv
// Shared defines for the MEM/WB stage: default widths, load-type encodings, zero word.
package mem_wb_stage_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefRegAw = 5;

  localparam logic [DefDataW-1:0] ZeroWord = '0;

  typedef enum logic [2:0] {
    LdLw  = 3'b000,
    LdLb  = 3'b001,
    LdLbu = 3'b010,
    LdLh  = 3'b011,
    LdLhu = 3'b100
  } load_type_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load aligner: picks the addressed byte/halfword from a little-endian word and extends it.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_addr_lo,
  input  logic [2:0]        i_load_type,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select; addr_lo[0] is deliberately ignored for halfwords (no misalignment trap).
  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extension by load kind; unknown encodings fall back to a full-word load.
  always_comb begin
    o_data = i_rdata;
    case (i_load_type)
      LdLb:    o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LdLbu:   o_data = {{(DATA_W-8){1'b0}}, w_byte};
      LdLh:    o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      LdLhu:   o_data = {{(DATA_W-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns load data, gates $0 writes, handles stall/flush, counts retires.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned REG_AW = DefRegAw
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_mem_valid,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_mem_wreg,
  input  logic [DATA_W-1:0] i_mem_alu_result,
  input  logic              i_mem_is_load,
  input  logic [2:0]        i_mem_load_type,
  input  logic [1:0]        i_mem_addr_lo,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_we,
  output logic [REG_AW-1:0] o_wb_write_reg,
  output logic [DATA_W-1:0] o_wb_write_data,
  output logic [31:0]       o_instret
);

  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_data_d;
  logic              w_we_d;

  logic              r_valid;
  logic              r_we;
  logic [REG_AW-1:0] r_wreg;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_instret;

  mem_wb_stage_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .i_rdata     (i_mem_rdata),
    .i_addr_lo   (i_mem_addr_lo),
    .i_load_type (i_mem_load_type),
    .o_data      (w_load_data)
  );

  // Next-state write data and enable; a write to $0 never reaches the register file.
  always_comb begin
    w_data_d = i_mem_is_load ? w_load_data : i_mem_alu_result;
    w_we_d   = i_mem_valid & i_mem_we & (i_mem_wreg != '0);
  end

  // Stage registers with priority rst > flush > stall > capture; flush keeps instret.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_we      <= 1'b0;
      r_wreg    <= '0;
      r_data    <= ZeroWord[DATA_W-1:0];
      r_instret <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_data  <= ZeroWord[DATA_W-1:0];
    end else if (!i_stall) begin
      r_valid <= i_mem_valid;
      r_we    <= w_we_d;
      r_wreg  <= i_mem_wreg;
      r_data  <= w_data_d;
      if (i_mem_valid) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign o_wb_valid      = r_valid;
  assign o_wb_we         = r_we;
  assign o_wb_write_reg  = r_wreg;
  assign o_wb_write_data = r_data;
  assign o_instret       = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_we;
  logic [4:0]  mem_wreg;
  logic [31:0] mem_alu_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic [31:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_stage dut (
    .clk              (clk),
    .rst              (rst),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_mem_valid      (mem_valid),
    .i_mem_we         (mem_we),
    .i_mem_wreg       (mem_wreg),
    .i_mem_alu_result (mem_alu_result),
    .i_mem_is_load    (mem_is_load),
    .i_mem_load_type  (mem_load_type),
    .i_mem_addr_lo    (mem_addr_lo),
    .i_mem_rdata      (mem_rdata),
    .o_wb_valid       (wb_valid),
    .o_wb_we          (wb_we),
    .o_wb_write_reg   (wb_write_reg),
    .o_wb_write_data  (wb_write_data),
    .o_instret        (instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic v, input logic we, input logic [4:0] rg,
                          input logic [31:0] data, input logic [31:0] ir);
    check({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, v});
    check({tag, ".we"}, {31'd0, wb_we}, {31'd0, we});
    check({tag, ".reg"}, {27'd0, wb_write_reg}, {27'd0, rg});
    check({tag, ".data"}, wb_write_data, data);
    check({tag, ".instret"}, instret, ir);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_we = 1'b0; mem_wreg = 5'd0; mem_alu_result = 32'h0;
    mem_is_load = 1'b0; mem_load_type = 3'b000; mem_addr_lo = 2'd0; mem_rdata = 32'h0;
    step();
    step();
    check_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
    rst = 1'b0;

    // ALU result write-back
    mem_valid = 1'b1; mem_we = 1'b1; mem_wreg = 5'd5; mem_alu_result = 32'h1234_5678;
    step();
    check_wb("alu", 1'b1, 1'b1, 5'd5, 32'h1234_5678, 32'd1);

    // Load alignment
    mem_is_load = 1'b1; mem_rdata = 32'h80FF_7F01; mem_wreg = 5'd6;
    mem_load_type = 3'b001; mem_addr_lo = 2'd3;
    step();
    check_wb("lb3", 1'b1, 1'b1, 5'd6, 32'hFFFF_FF80, 32'd2);
    mem_load_type = 3'b010;
    step();
    check("lbu3.data", wb_write_data, 32'h0000_0080);
    mem_load_type = 3'b011; mem_addr_lo = 2'd2;
    step();
    check("lh2.data", wb_write_data, 32'hFFFF_80FF);
    mem_load_type = 3'b100; mem_addr_lo = 2'd0;
    step();
    check("lhu0.data", wb_write_data, 32'h0000_7F01);
    mem_load_type = 3'b000; mem_addr_lo = 2'd1;
    step();
    check("lb1_as_lw", wb_write_data, 32'h80FF_7F01);
    mem_load_type = 3'b001;
    step();
    check("lb1.data", wb_write_data, 32'h0000_007F);
    mem_load_type = 3'b011; mem_addr_lo = 2'd1;
    step();
    check("lh1.data", wb_write_data, 32'h0000_7F01);
    mem_load_type = 3'b111; mem_addr_lo = 2'd3;
    step();
    check_wb("bad_type", 1'b1, 1'b1, 5'd6, 32'h80FF_7F01, 32'd9);

    // Write to $0 is suppressed but still retires
    mem_is_load = 1'b0; mem_wreg = 5'd0; mem_alu_result = 32'hAAAA_5555;
    step();
    check_wb("r0", 1'b1, 1'b0, 5'd0, 32'hAAAA_5555, 32'd10);

    // Capture then stall for 3 edges with changing inputs
    mem_wreg = 5'd9; mem_alu_result = 32'h0000_00C3;
    step();
    check_wb("pre_stall", 1'b1, 1'b1, 5'd9, 32'h0000_00C3, 32'd11);
    stall = 1'b1; mem_wreg = 5'd10; mem_alu_result = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_wb("stall", 1'b1, 1'b1, 5'd9, 32'h0000_00C3, 32'd11);
    end
    flush = 1'b1;
    step();
    check_wb("stall_flush", 1'b0, 1'b0, 5'd0, 32'h0, 32'd11);
    stall = 1'b0;
    step();
    check_wb("flush", 1'b0, 1'b0, 5'd0, 32'h0, 32'd11);
    flush = 1'b0;

    // Bubble does not retire
    mem_valid = 1'b0;
    step();
    check_wb("bubble", 1'b0, 1'b0, 5'd10, 32'hDEAD_BEEF, 32'd11);

    // Counter wrap
    force dut.r_instret = 32'hFFFF_FFFE;
    step();
    release dut.r_instret;
    mem_valid = 1'b1; mem_wreg = 5'd3; mem_alu_result = 32'h1;
    step();
    check("wrap_pre", instret, 32'hFFFF_FFFF);
    step();
    check("wrap", instret, 32'h0);
    step();
    check("wrap_post", instret, 32'h1);

    // Reset asserted mid-stall, then stall persists after reset
    stall = 1'b1; rst = 1'b1;
    step();
    check_wb("rst_mid", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
    rst = 1'b0;
    step();
    check_wb("post_rst_stall", 1'b0, 1'b0, 5'd0, 32'h0, 32'd0);
    stall = 1'b0;
    step();
    check_wb("post_rst_cap", 1'b1, 1'b1, 5'd3, 32'h1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register between the memory-access stage and the register file's write-back port. It latches the MEM-stage result, sign- or zero-extends and aligns load data, and drives `wb_we`, `wb_write_reg` and `wb_write_data` into the register file. It also honours pipeline stall/flush and keeps a retired-instruction counter for debug and performance readout.

## Interface

Reset is `rst`, synchronous, active-high. Clock is `clk`.

- `DATA_W`, 32: datapath width.
- `REG_AW`, 5: register address width.
- `clk`  in  1: clock, all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold all stage registers.
- `flush`  in  1: replace the stage contents with a bubble.
- `mem_valid`  in  1: the MEM stage holds a real instruction.
- `mem_we`  in  1: the instruction writes a register.
- `mem_wreg`  in  REG_AW: destination register.
- `mem_alu_result`  in  DATA_W: ALU or address result for non-loads.
- `mem_is_load`  in  1: select load data instead of the ALU result.
- `mem_load_type`  in  3: load kind; the encodings are in the shared defines.
- `mem_addr_lo`  in  2: effective address bits [1:0].
- `mem_rdata`  in  DATA_W: raw word from data memory, valid in the same cycle.
- `wb_valid`  out  1: the WB stage holds a real instruction.
- `wb_we`  out  1: register-file write enable.
- `wb_write_reg`  out  REG_AW: register-file write address.
- `wb_write_data`  out  DATA_W: register-file write data.
- `instret`  out  32: count of retired instructions.

## Operation

- Load kinds (from the shared defines): LW=3'b000, LB=3'b001, LBU=3'b010, LH=3'b011, LHU=3'b100. Any other encoding behaves as LW.
- Byte lanes are little-endian: `mem_addr_lo`=0 selects bits [7:0], 1 selects [15:8], 2 selects [23:16], 3 selects [31:24].
- Halfword lane is selected by `mem_addr_lo[1]` (0 selects [15:0], 1 selects [31:16]). `mem_addr_lo[0]` is ignored for halfwords; there is no misalignment trap.
- LB and LH sign-extend to DATA_W. LBU and LHU zero-extend.
- Next-state data is the aligned load data when `mem_is_load`, otherwise `mem_alu_result`.
- `wb_we` is loaded as `mem_valid & mem_we & (mem_wreg != 0)`. A write to $0 is never issued, so downstream forwarding logic can trust `wb_we`.
- Update priority per rising edge is `rst` > `flush` > `stall` > normal load.
  - `rst`: every output goes to 0.
  - `flush`: `wb_valid`, `wb_we`, `wb_write_reg` and `wb_write_data` go to 0. `instret` is held.
  - `stall` (without flush): all registers, including `instret`, hold their value.
  - Normal load: capture the MEM-stage values.
- `instret` increments by 1 on every edge where a normal load captures `mem_valid`=1. It wraps from 0xFFFFFFFF to 0.
- A flush in the same cycle as a stall produces a bubble; flush wins.

## Timing

- Reset value of all outputs is 0; `instret` is also 0.
- Latency is 1 cycle from MEM inputs to WB outputs. The register file commits on the following edge and bypasses same-cycle reads internally.
- `mem_rdata` is sampled in the same cycle as the other MEM inputs. No extra wait state.
- Outputs are purely registered; there is no combinational path from any input to any output.
- If `rst` is asserted mid-stall, the state clears on that edge. After `rst` deasserts, the first capture happens on the next edge that has neither stall nor flush.
- While `stall` is held for N cycles, `wb_we` stays asserted with the same data. The register-file rewrite is idempotent, which is the required behaviour.

## Structure

- The shared defines include holds the load-type constants, `ZeroWord`, and the `DATA_W`/`REG_AW` defaults.
- One sub-module, `load_align`: combinational, takes (`mem_rdata`, `mem_addr_lo`, `mem_load_type`) and produces the aligned word. It is unit-testable on its own.
- The top level holds the pipeline registers, the priority logic and the `instret` counter.

## Test plan

- Reset, then `mem_valid`=1, `mem_we`=1, `mem_wreg`=5, `mem_alu_result`=0x1234_5678 → one cycle later `wb_we`=1, `wb_write_reg`=5, `wb_write_data`=0x1234_5678, `instret`=1.
- LB with `mem_rdata`=0x80FF_7F01:
  - `mem_addr_lo`=3 → `wb_write_data`=0xFFFF_FF80.
  - The same access as LBU → 0x0000_0080.
  - LH with `mem_addr_lo`=2 → 0xFFFF_80FF.
  - LHU with `mem_addr_lo`=0 → 0x0000_7F01.
- `mem_we`=1, `mem_wreg`=0 → `wb_we`=0 and `wb_valid`=1; `instret` still increments.
- `stall` held 3 cycles after a capture → outputs and `instret` are unchanged for 3 edges. `stall`+`flush` together → `wb_valid`=`wb_we`=0 and `instret` is unchanged.
- Force `instret` to 0xFFFF_FFFF via a run, then retire one more instruction → `instret`=0. Assert `rst` mid-run → all outputs read 0 on the next edge.
